// File: rtl/rv_scoreboard_if.sv
// Issue/writeback/hazard bundle between the decode stage and the register scoreboard.
interface rv_scoreboard_if #(
    parameter int STALL_CNT_W = 16
);
    logic [31:0]            ifid_i;
    logic                   issue_valid;
    logic                   issue_we;
    logic [4:0]             issue_rd;
    logic                   wb_valid;
    logic [4:0]             wb_rd;
    logic                   flush;
    logic                   stall;
    logic                   pc_write;
    logic                   ifid_write;
    logic [31:0]            busy_vec;
    logic [STALL_CNT_W-1:0] stall_cycles;
    logic                   wb_err;

    modport master (
        output ifid_i, issue_valid, issue_we, issue_rd, wb_valid, wb_rd, flush,
        input  stall, pc_write, ifid_write, busy_vec, stall_cycles, wb_err
    );

    modport slave (
        input  ifid_i, issue_valid, issue_we, issue_rd, wb_valid, wb_rd, flush,
        output stall, pc_write, ifid_write, busy_vec, stall_cycles, wb_err
    );
endinterface

// File: rtl/rv_scoreboard.sv
// Register scoreboard: 2-bit outstanding-write counters per architectural register,
// read-after-write stall generation, stall-cycle statistics and a sticky writeback error.
module rv_scoreboard #(
    parameter int STALL_CNT_W = 16
) (
    input logic        clk,
    input logic        rst_n,
    rv_scoreboard_if.slave sb
);
    logic [1:0]             cnt_reg  [1:31];
    logic [1:0]             cnt_next [1:31];
    logic [1:0]             cnt_view [0:31];
    logic                   busy_reg [1:31];
    logic [31:0]            busy_vec;
    logic [STALL_CNT_W-1:0] stall_cycles_reg;
    logic                   wb_err_reg;

    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       stall;
    logic       issue_acc;
    logic       wb_hit;
    logic       wb_zero;

    assign rs1 = sb.ifid_i[19:15];
    assign rs2 = sb.ifid_i[24:20];

    // x0 never has a producer, so its view is hard-wired to an empty counter.
    assign cnt_view[0] = 2'd0;
    assign busy_vec[0] = 1'b0;

    // Stall only looks at registered state and current decode inputs, never at this cycle's writeback.
    assign stall = busy_vec[rs1] | busy_vec[rs2]
                 | (sb.issue_we && (sb.issue_rd != 5'd0) && (cnt_view[sb.issue_rd] == 2'd3));

    assign issue_acc = sb.issue_valid && !stall && sb.issue_we && (sb.issue_rd != 5'd0);
    assign wb_hit    = sb.wb_valid && (sb.wb_rd != 5'd0);
    assign wb_zero   = wb_hit && (cnt_view[sb.wb_rd] == 2'd0);

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_cnt
            logic inc;
            logic dec;

            assign cnt_view[gi] = cnt_reg[gi];
            assign busy_vec[gi] = busy_reg[gi];

            always_comb begin
                inc          = issue_acc && (sb.issue_rd == 5'(gi));
                dec          = wb_hit && (sb.wb_rd == 5'(gi)) && (cnt_reg[gi] != 2'd0);
                cnt_next[gi] = cnt_reg[gi];
                if (sb.flush) begin
                    cnt_next[gi] = 2'd0;
                end else if (inc && !dec) begin
                    cnt_next[gi] = cnt_reg[gi] + 2'd1;
                end else if (dec && !inc) begin
                    cnt_next[gi] = cnt_reg[gi] - 2'd1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg[gi]  <= 2'd0;
                    busy_reg[gi] <= 1'b0;
                end else begin
                    cnt_reg[gi]  <= cnt_next[gi];
                    busy_reg[gi] <= (cnt_next[gi] != 2'd0);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_reg <= '0;
            wb_err_reg       <= 1'b0;
        end else begin
            if (stall && (stall_cycles_reg != {STALL_CNT_W{1'b1}})) begin
                stall_cycles_reg <= stall_cycles_reg + 1'b1;
            end
            if (wb_zero) begin
                wb_err_reg <= 1'b1;
            end
        end
    end

    assign sb.stall        = stall;
    assign sb.pc_write     = ~stall;
    assign sb.ifid_write   = ~stall;
    assign sb.busy_vec     = busy_vec;
    assign sb.stall_cycles = stall_cycles_reg;
    assign sb.wb_err       = wb_err_reg;
endmodule

// File: tb/tb_rv_scoreboard.sv
// Scenario and randomized checks of rv_scoreboard against an array-of-counts reference model.
module tb_rv_scoreboard;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rv_scoreboard_if #(.STALL_CNT_W(16)) sb_if();
    rv_scoreboard #(.STALL_CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .sb(sb_if.slave));

    int checks = 0;
    int errors = 0;
    int mcnt [32];
    bit merr;
    int msc;

    function automatic logic [31:0] make_ifid(int rs1, int rs2);
        return {7'h00, 5'(rs2), 5'(rs1), 3'b000, 5'd1, 7'h33};
    endfunction

    function automatic bit model_stall();
        int r1 = int'(sb_if.ifid_i[19:15]);
        int r2 = int'(sb_if.ifid_i[24:20]);
        int rd = int'(sb_if.issue_rd);
        return (r1 != 0 && mcnt[r1] > 0) || (r2 != 0 && mcnt[r2] > 0)
            || (sb_if.issue_we && rd != 0 && mcnt[rd] == 3);
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] v = '0;
        for (int r = 1; r < 32; r++) v[r] = (mcnt[r] > 0);
        return v;
    endfunction

    task automatic drive(bit iv, bit we, int rd, bit wv, int wrd, bit fl, int rs1, int rs2);
        sb_if.issue_valid = iv;
        sb_if.issue_we    = we;
        sb_if.issue_rd    = 5'(rd);
        sb_if.wb_valid    = wv;
        sb_if.wb_rd       = 5'(wrd);
        sb_if.flush       = fl;
        sb_if.ifid_i      = make_ifid(rs1, rs2);
    endtask

    // Apply one clock edge to both the model and the DUT.
    task automatic tick();
        int pre [32];
        bit st  = model_stall();
        int rd  = int'(sb_if.issue_rd);
        int wrd = int'(sb_if.wb_rd);
        bit acc = sb_if.issue_valid && !st && sb_if.issue_we && rd != 0;
        bit wbv = sb_if.wb_valid && wrd != 0;
        pre = mcnt;
        if (wbv && pre[wrd] == 0) merr = 1'b1;
        if (sb_if.flush) begin
            for (int r = 0; r < 32; r++) mcnt[r] = 0;
        end else begin
            if (acc) mcnt[rd] = mcnt[rd] + 1;
            if (wbv && pre[wrd] > 0) mcnt[wrd] = mcnt[wrd] - 1;
        end
        if (st && msc < 65535) msc = msc + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
        merr = 1'b0;
        msc  = 0;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (sb_if.busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp %h", sb_if.busy_vec, 32'h0); end
        if (sb_if.stall_cycles !== 16'h0) begin errors++; $display("FAIL reset_sc got %h exp 0", sb_if.stall_cycles); end
        if (sb_if.wb_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", sb_if.wb_err); end
        if (sb_if.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", sb_if.stall); end
        if (sb_if.pc_write !== 1'b1) begin errors++; $display("FAIL reset_pcw got %b exp 1", sb_if.pc_write); end
        if (sb_if.ifid_write !== 1'b1) begin errors++; $display("FAIL reset_ifw got %b exp 1", sb_if.ifid_write); end
        $display("txn reset: busy=%h sc=%0d err=%b", sb_if.busy_vec, sb_if.stall_cycles, sb_if.wb_err);
    endtask

    task automatic test_raw_hazard();
        drive(1, 1, 5, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (sb_if.busy_vec[5] !== 1'b1) begin errors++; $display("FAIL raw_busy5 got %b exp 1", sb_if.busy_vec[5]); end
        drive(0, 0, 0, 0, 0, 0, 5, 0);
        #1;
        checks += 3;
        if (sb_if.stall !== 1'b1) begin errors++; $display("FAIL raw_stall got %b exp 1", sb_if.stall); end
        if (sb_if.pc_write !== 1'b0) begin errors++; $display("FAIL raw_pcw got %b exp 0", sb_if.pc_write); end
        if (sb_if.ifid_write !== 1'b0) begin errors++; $display("FAIL raw_ifw got %b exp 0", sb_if.ifid_write); end
        tick();
        drive(0, 0, 0, 1, 5, 0, 5, 0);
        #1;
        checks++;
        if (sb_if.stall !== 1'b1) begin errors++; $display("FAIL raw_wb_same_cycle got %b exp 1", sb_if.stall); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 5, 0);
        #1;
        checks += 3;
        if (sb_if.stall !== 1'b0) begin errors++; $display("FAIL raw_release got %b exp 0", sb_if.stall); end
        if (sb_if.busy_vec[5] !== 1'b0) begin errors++; $display("FAIL raw_busy5_clr got %b exp 0", sb_if.busy_vec[5]); end
        if (sb_if.stall_cycles !== 16'd2) begin errors++; $display("FAIL raw_sc got %0d exp 2", sb_if.stall_cycles); end
        $display("txn raw_hazard: rd=5 stall_cycles=%0d", sb_if.stall_cycles);
    endtask

    task automatic test_rd0();
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks += 2;
        if (sb_if.stall !== 1'b0) begin errors++; $display("FAIL rd0_stall got %b exp 0", sb_if.stall); end
        if (sb_if.busy_vec !== 32'h0) begin errors++; $display("FAIL rd0_busy got %h exp 0", sb_if.busy_vec); end
        $display("txn rd0: busy=%h", sb_if.busy_vec);
    endtask

    task automatic test_count_sat();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 7, 0, 0, 0, 0, 0);
            #1;
            checks++;
            if (sb_if.stall !== 1'b0) begin errors++; $display("FAIL sat_issue%0d_stall got %b exp 0", i, sb_if.stall); end
            tick();
        end
        drive(1, 1, 7, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (sb_if.stall !== 1'b1) begin errors++; $display("FAIL sat_fourth_stall got %b exp 1", sb_if.stall); end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 7, 0, 0, 0);
            tick();
            checks++;
            if (sb_if.busy_vec[7] !== (i < 2)) begin errors++; $display("FAIL sat_wb%0d_busy7 got %b exp %b", i, sb_if.busy_vec[7], i < 2); end
        end
        checks++;
        if (sb_if.wb_err !== 1'b0) begin errors++; $display("FAIL sat_err got %b exp 0", sb_if.wb_err); end
        $display("txn count_sat: rd=7 busy=%h err=%b", sb_if.busy_vec, sb_if.wb_err);
    endtask

    task automatic test_same_cycle();
        drive(1, 1, 9, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 9, 1, 9, 0, 0, 0);
        tick();
        checks++;
        if (sb_if.busy_vec[9] !== 1'b1) begin errors++; $display("FAIL same_busy9 got %b exp 1", sb_if.busy_vec[9]); end
        drive(0, 0, 0, 1, 9, 0, 0, 0);
        tick();
        checks += 2;
        if (sb_if.busy_vec[9] !== 1'b0) begin errors++; $display("FAIL same_busy9_clr got %b exp 0", sb_if.busy_vec[9]); end
        if (sb_if.wb_err !== 1'b0) begin errors++; $display("FAIL same_err_early got %b exp 0", sb_if.wb_err); end
        drive(0, 0, 0, 1, 9, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (sb_if.wb_err !== 1'b1) begin errors++; $display("FAIL same_err_sticky got %b exp 1", sb_if.wb_err); end
        $display("txn same_cycle: rd=9 err=%b", sb_if.wb_err);
    endtask

    task automatic test_flush();
        do_reset();
        foreach (mcnt[r]) if (r == 1 || r == 2 || r == 8) begin
            drive(1, 1, r, 0, 0, 0, 0, 0);
            tick();
        end
        checks++;
        if (sb_if.busy_vec !== 32'h0000_0106) begin errors++; $display("FAIL flush_pre_busy got %h exp 00000106", sb_if.busy_vec); end
        drive(1, 1, 3, 0, 0, 1, 0, 0);
        tick();
        checks += 2;
        if (sb_if.busy_vec !== 32'h0) begin errors++; $display("FAIL flush_busy got %h exp 0", sb_if.busy_vec); end
        if (sb_if.stall_cycles !== 16'(msc)) begin errors++; $display("FAIL flush_sc got %0d exp %0d", sb_if.stall_cycles, msc); end
        drive(1, 1, 8, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 8, 0);
        #1;
        checks++;
        if (sb_if.stall !== 1'b1) begin errors++; $display("FAIL flush_cycle_stall got %b exp 1", sb_if.stall); end
        tick();
        checks += 2;
        if (sb_if.busy_vec !== 32'h0) begin errors++; $display("FAIL flush2_busy got %h exp 0", sb_if.busy_vec); end
        if (sb_if.stall_cycles !== 16'd1) begin errors++; $display("FAIL flush2_sc got %0d exp 1", sb_if.stall_cycles); end
        $display("txn flush: busy=%h sc=%0d", sb_if.busy_vec, sb_if.stall_cycles);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            int rd   = int'($urandom_range(0, 7));
            bit iv   = ($urandom_range(0, 3) != 0);
            bit we   = ($urandom_range(0, 4) != 0);
            bit wv   = ($urandom_range(0, 2) == 0);
            int wrd  = int'($urandom_range(0, 7));
            bit fl   = ($urandom_range(0, 39) == 0);
            int rs1  = int'($urandom_range(0, 15));
            int rs2  = int'($urandom_range(0, 15));
            bit exp_st;
            for (int k = 0; k < 8 && mcnt[wrd] == 0; k++) wrd = int'($urandom_range(1, 7));
            if (fl) wv = 1'b0;
            if (wv && wrd == rd && mcnt[wrd] == 0) wv = 1'b0;
            drive(iv, we, rd, wv, wrd, fl, rs1, rs2);
            #1;
            exp_st = model_stall();
            checks += 2;
            if (sb_if.stall !== exp_st) begin errors++; $display("FAIL rnd%0d_stall got %b exp %b", n, sb_if.stall, exp_st); end
            if (sb_if.pc_write !== !exp_st) begin errors++; $display("FAIL rnd%0d_pcw got %b exp %b", n, sb_if.pc_write, !exp_st); end
            tick();
            checks += 3;
            if (sb_if.busy_vec !== model_busy()) begin errors++; $display("FAIL rnd%0d_busy got %h exp %h", n, sb_if.busy_vec, model_busy()); end
            if (sb_if.wb_err !== merr) begin errors++; $display("FAIL rnd%0d_err got %b exp %b", n, sb_if.wb_err, merr); end
            if (sb_if.stall_cycles !== 16'(msc)) begin errors++; $display("FAIL rnd%0d_sc got %0d exp %0d", n, sb_if.stall_cycles, msc); end
            $display("txn rnd%0d: iv=%b we=%b rd=%0d wv=%b wrd=%0d fl=%b rs=%0d/%0d stall=%b busy=%h",
                     n, iv, we, rd, wv, wrd, fl, rs1, rs2, exp_st, sb_if.busy_vec);
        end
    endtask

    task automatic test_stall_sat();
        do_reset();
        drive(1, 1, 4, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 4, 0);
        for (int i = 0; i < 70000; i++) tick();
        checks += 2;
        if (sb_if.stall_cycles !== 16'hFFFF) begin errors++; $display("FAIL stall_sat got %h exp ffff", sb_if.stall_cycles); end
        if (sb_if.stall_cycles !== 16'(msc)) begin errors++; $display("FAIL stall_sat_model got %0d exp %0d", sb_if.stall_cycles, msc); end
        $display("txn stall_sat: sc=%h", sb_if.stall_cycles);
    endtask

    task automatic test_async_reset();
        drive(0, 0, 0, 1, 10, 0, 0, 0);
        tick();
        checks++;
        if (sb_if.wb_err !== 1'b1) begin errors++; $display("FAIL ar_pre_err got %b exp 1", sb_if.wb_err); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (sb_if.busy_vec !== 32'h0) begin errors++; $display("FAIL ar_busy got %h exp 0", sb_if.busy_vec); end
        if (sb_if.stall_cycles !== 16'h0) begin errors++; $display("FAIL ar_sc got %h exp 0", sb_if.stall_cycles); end
        if (sb_if.wb_err !== 1'b0) begin errors++; $display("FAIL ar_err got %b exp 0", sb_if.wb_err); end
        if (sb_if.stall !== 1'b0) begin errors++; $display("FAIL ar_stall got %b exp 0", sb_if.stall); end
        if (sb_if.pc_write !== 1'b1) begin errors++; $display("FAIL ar_pcw got %b exp 1", sb_if.pc_write); end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(0, 0, 0, 1, 4, 0, 0, 0);
        tick();
        checks++;
        if (sb_if.wb_err !== 1'b1) begin errors++; $display("FAIL ar_stale_wb_err got %b exp 1", sb_if.wb_err); end
        $display("txn async_reset: err_after_stale_wb=%b", sb_if.wb_err);
    endtask

    initial begin
        rst_n = 1'b0;
        model_clear();
        test_reset();
        test_raw_hazard();
        test_rd0();
        test_count_sat();
        test_same_cycle();
        test_flush();
        test_random();
        test_stall_sat();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv_scoreboard.md
RV_SCOREBOARD -- requirements
Module: rv_scoreboard

Interface
REQ-001: Parameter STALL_CNT_W, default 16, width of the saturating stall-cycle counter.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst_n  input  1  asynchronous, active-low reset.
REQ-004: ifid_i  input  32  instruction in IF/ID; rs1 = ifid_i[19:15], rs2 = ifid_i[24:20].
REQ-005: issue_valid  input  1  ID stage issuing ifid_i into EX this cycle.
REQ-006: issue_we  input  1  issued instruction writes a destination register.
REQ-007: issue_rd  input  5  destination register of issued instruction.
REQ-008: wb_valid  input  1  a producer is writing back this cycle.
REQ-009: wb_rd  input  5  register being written back.
REQ-010: flush  input  1  pipeline flush; discard all in-flight producers.
REQ-011: stall  output  1  combinational; hold IF/ID and PC this cycle.
REQ-012: pc_write  output  1  combinational; equals ~stall.
REQ-013: ifid_write  output  1  combinational; equals ~stall.
REQ-014: busy_vec  output  32  registered; bit r = 1 when reg r has pending count > 0.
REQ-015: stall_cycles  output  STALL_CNT_W  registered saturating count of stalled cycles.
REQ-016: wb_err  output  1  registered sticky; writeback to a register with count 0.

Function
REQ-017: Block SHALL hold a 2-bit outstanding-write counter per register r = 1..31; register 0 has no counter and SHALL always read as not pending.
REQ-018: stall SHALL be 1 when busy_vec[rs1] or busy_vec[rs2] is 1 (both fields always compared), or when issue_we=1 and count[issue_rd]=3 with issue_rd != 0.
REQ-019: stall SHALL depend only on registered counters and current inputs (no dependence on same-cycle wb_valid).
REQ-020: Issue accepted when issue_valid=1, stall=0, issue_we=1, issue_rd != 0; accepted issue increments count[issue_rd] at next edge.
REQ-021: issue_valid while stall=1 SHALL be ignored (no counter change).
REQ-022: wb_valid=1, wb_rd != 0, count[wb_rd] > 0 SHALL decrement count[wb_rd] at next edge.
REQ-023: wb_valid=1, wb_rd != 0, count[wb_rd] = 0 SHALL leave counter at 0 and set wb_err=1 until reset.
REQ-024: Accepted issue and valid writeback to the same register in one cycle SHALL leave that count unchanged; to different registers both apply.
REQ-025: Counters SHALL never wrap: max 3 (enforced by REQ-018), min 0 (REQ-023).
REQ-026: flush=1 SHALL clear all counters at next edge, overriding same-cycle issue and writeback; stall SHALL still be computed from current counters during the flush cycle.
REQ-027: busy_vec SHALL reflect counters after the edge (one-cycle latency from issue/writeback to busy_vec).
REQ-028: stall_cycles SHALL increment each cycle stall=1, saturating at all-ones; flush SHALL NOT clear it.

Reset
REQ-029: rst_n=0 SHALL asynchronously clear all counters, busy_vec=0, stall_cycles=0, wb_err=0; stall=0 and pc_write=ifid_write=1 while ifid_i sources no busy register.
REQ-030: Reset asserted mid-operation SHALL discard all pending state; no writeback after release may set wb_err for pre-reset producers only if it targets a zero counter (normal REQ-023 rule).

Verification
REQ-031: Issue rd=5; next cycle ifid_i rs1=5 -> stall=1, pc_write=0, busy_vec[5]=1; wb rd=5 -> following cycle stall=0, busy_vec[5]=0.
REQ-032: Issue rd=0 then ifid_i rs1=0 -> no counter change, stall=0, busy_vec=0.
REQ-033: Three accepted issues to rd=7 -> count 3; fourth issue_we with rd=7 -> stall=1, count stays 3; three wb rd=7 -> busy_vec[7]=0, wb_err=0.
REQ-034: Count[9]=1, same-cycle issue rd=9 and wb rd=9 -> count[9]=1, busy_vec[9]=1; wb rd=9 on count 0 -> wb_err=1 sticky.
REQ-035: busy_vec=0x0000_0106, flush=1 with simultaneous issue rd=3 -> next cycle busy_vec=0; stall_cycles unchanged by flush.
REQ-036: 70000 consecutive stall cycles with STALL_CNT_W=16 -> stall_cycles=0xFFFF; async rst_n pulse mid-cycle -> all outputs at reset values immediately.
